pu_riscv_ahb3_slave_mem: RTL and testbench
==========================================

Name: pu_riscv_ahb3_slave_mem

Overview:
AHB3-Lite slave (responder) memory. It terminates the transfers issued by the PU-RISCV instruction/data AHB3 masters and supports programmable wait states. It decodes ERROR responses for out-of-range, misaligned and oversize accesses. It is used as boot/scratch memory and as the bench-side responder for the ins_/dat_ AHB3 ports of the processing unit.

Parameters:
XLEN, 64, data bus width in bits; 32 or 64.
PLEN, 64, address bus width in bits.
BASE_ADDR, 'h8000_0000, first byte address served.
MEM_DEPTH, 256, number of XLEN-bit words; power of two.
WAIT_STATES, 0, wait cycles inserted before completing each OKAY transfer; 0..15.

Ports:
HCLK  input  1  clock; all state updates on the rising edge.
HRESET  input  1  asynchronous, active-high reset.
HSEL  input  1  slave select.
HADDR  input  PLEN  byte address, address phase.
HWDATA  input  XLEN  write data, data phase.
HRDATA  output  XLEN  read data, data phase.
HWRITE  input  1  1=write, 0=read.
HSIZE  input  3  transfer size, log2 of bytes.
HBURST  input  3  burst type; ignored.
HPROT  input  4  protection; ignored.
HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HMASTLOCK  input  1  lock; ignored.
HREADY  input  1  bus-level ready (HREADYOUT after the interconnect mux).
HREADYOUT  output  1  this slave's ready.
HRESP  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (asynchronous on HRESET=1): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, latched address-phase registers cleared. Memory contents are not reset. Reset mid-transfer discards any pending write.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. On accept, latch HADDR, HSIZE and HWRITE, and compute the error flag.
- Error flag is set when any of:
  - HSIZE > log2(XLEN/8);
  - HADDR not aligned to 2^HSIZE;
  - HADDR < BASE_ADDR;
  - HADDR-BASE_ADDR >= MEM_DEPTH*XLEN/8.
- IDLE/BUSY or unselected transfers: no access, HREADYOUT=1, HRESP=0 in the following cycle.
- SEQ is handled exactly like NONSEQ. Every beat is decoded independently; HBURST is not used.
- State machine:
  - IDLE: on accept with error -> ERR1. On accept, no error, WAIT_STATES>0 -> WAIT with counter=WAIT_STATES-1. On accept, no error, WAIT_STATES=0 -> DATA. Otherwise stay in IDLE.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0. This is the completing cycle. A new accept in the same cycle (pipelined) re-enters WAIT/DATA/ERR1 using the same rules as IDLE; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next-transfer accept rules are the same as DATA.
- Wait states apply only to OKAY transfers. An ERROR response is always exactly 2 cycles.
- Read: in the DATA cycle, HRDATA = mem[word index] (combinational from the latched address). HRDATA=0 in all other states and for writes.
- Write: on the rising edge ending the DATA cycle, write HWDATA to mem[word index] under byte enables. Byte enables = (2^(2^HSIZE))-1 shifted left by HADDR[log2(XLEN/8)-1:0]. Unselected bytes are unchanged.
- Write followed by a read to the same address back-to-back: the read returns the new data (the write commits before the read data phase).
- Word index = (HADDR-BASE_ADDR) >> log2(XLEN/8), truncated to log2(MEM_DEPTH) bits.
- Errored transfers never modify memory.
- Throughput: with WAIT_STATES=0, one transfer per cycle.

Decomposition:
- Package pu_riscv_ahb3_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR;
  - HSIZE_B8..HSIZE_B64 encodings;
  - the state enum {IDLE, WAIT, DATA, ERR1, ERR2}.
- One sub-module is natural: pu_riscv_ahb3_be_gen (HSIZE + low address bits -> XLEN/8 byte enables plus the misaligned/oversize flag). It is reusable by other AHB3 slaves.

Test Plan (XLEN=64, MEM_DEPTH=256, BASE_ADDR='h8000_0000, WAIT_STATES=0 unless stated):
- Reset: HRESET pulse mid-write -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; target word unchanged.
- Pipelined access: NONSEQ write 64-bit 'h0123_4567_89AB_CDEF to 'h8000_0010, immediately followed by NONSEQ read of 'h8000_0010 -> zero wait states; read data phase returns 'h0123_4567_89AB_CDEF.
- Byte write: HSIZE=0 write 'hXX..AA to 'h8000_0013 over a word of 0 -> read returns 'h0000_0000_AA00_0000; other bytes unchanged.
- Wait states: WAIT_STATES=3, read -> exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with data; next address not sampled during the waits.
- Errors:
  - read at 'h8000_0800 (out of range) -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1);
  - misaligned HSIZE=2 write at 'h8000_0002 -> same 2-cycle ERROR; memory unchanged.
- IDLE/BUSY: HTRANS=BUSY and HTRANS=IDLE with HSEL=1 -> OKAY, zero wait, no memory access; HSEL=0 with NONSEQ -> ignored.

Source files
------------

// File: rtl/pu_riscv_ahb3_pkg.sv
// ---------------------------------------------------------------------------
// pu_riscv_ahb3_pkg
//   Shared AHB3-Lite encodings and the responder state type used by the
//   PU-RISCV AHB3 slave memory and any other AHB3 slave in this slice.
//   No ports; import with "import pu_riscv_ahb3_pkg::*;".
// ---------------------------------------------------------------------------
package pu_riscv_ahb3_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // HSIZE encodings (log2 of the transfer size in bytes)
  localparam logic [2:0] HSIZE_B8   = 3'b000;
  localparam logic [2:0] HSIZE_B16  = 3'b001;
  localparam logic [2:0] HSIZE_B32  = 3'b010;
  localparam logic [2:0] HSIZE_B64  = 3'b011;
  localparam logic [2:0] HSIZE_B128 = 3'b100;

  // Responder data-phase state.
  //   ST_IDLE : no data phase in progress (ready, OKAY)
  //   ST_WAIT : OKAY transfer stalled by programmed wait states
  //   ST_DATA : completing cycle of an OKAY transfer
  //   ST_ERR1 : first ERROR cycle (HREADYOUT low)
  //   ST_ERR2 : second ERROR cycle (HREADYOUT high)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb3_state_t;

endpackage

// File: rtl/pu_riscv_ahb3_slave_mem_if.sv
// ---------------------------------------------------------------------------
// pu_riscv_ahb3_slave_mem_if
//   AHB3-Lite bus bundle between a master (or interconnect) and one slave.
//
//   Handshake: an address phase is taken by the slave on a rising edge where
//   HSEL & HREADY & HTRANS[1] are all high. The following cycle(s) are that
//   transfer's data phase, which ends on the first rising edge where HREADY
//   is high; HREADY low stalls both the pending data phase and the next
//   address phase, so the master must hold its address/control (and HWDATA
//   for writes) stable while HREADY is low. HRESP qualifies the data phase.
//
//   Parameters: XLEN (data width), PLEN (address width).
//   Modports  : master (drives address/control/HWDATA, sees response),
//               slave  (the reverse). HREADY is the muxed bus ready.
// ---------------------------------------------------------------------------
interface pu_riscv_ahb3_slave_mem_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);

  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HREADYOUT;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/pu_riscv_ahb3_be_gen.sv
// ---------------------------------------------------------------------------
// pu_riscv_ahb3_be_gen
//   Byte-enable generator for AHB3 slaves. Converts HSIZE and the low
//   address bits into XLEN/8 byte lane enables and flags transfers that are
//   wider than the bus or not naturally aligned.
//
//   Ports:
//     hsize   in  3        transfer size, log2 of bytes
//     addr_lo in  log2(XLEN/8) low byte-address bits
//     be      out XLEN/8   byte lane enables (all zero when err is set)
//     err     out 1        oversize or misaligned transfer
// ---------------------------------------------------------------------------
module pu_riscv_ahb3_be_gen #(
  parameter int XLEN = 64
) (
  input  logic [2:0]                  hsize,
  input  logic [$clog2(XLEN/8)-1:0]   addr_lo,
  output logic [XLEN/8-1:0]           be,
  output logic                        err
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(NB);

  logic [31:0] size_mask;
  logic [31:0] lane_mask;
  logic [31:0] be_wide;
  logic        oversize;
  logic        misalign;
  logic        unused_be;

  always_comb begin
    // Address bits that must be zero for a naturally aligned transfer.
    size_mask = (32'd1 << hsize) - 32'd1;
    oversize  = (32'(hsize) > 32'(AW));
    misalign  = (32'(addr_lo) & size_mask) != 32'd0;
    // 2^(2^hsize)-1 : one bit per byte of the transfer. For illegal sizes
    // the shift overflows, but the result is discarded through err.
    lane_mask = (32'd1 << (32'd1 << hsize)) - 32'd1;
    be_wide   = lane_mask << addr_lo;
    err       = oversize | misalign;
    be        = err ? '0 : be_wide[NB-1:0];
  end

  assign unused_be = ^be_wide[31:NB];

endmodule

// File: rtl/pu_riscv_ahb3_slave_mem.sv
// ---------------------------------------------------------------------------
// pu_riscv_ahb3_slave_mem
//   AHB3-Lite responder memory for the PU-RISCV instruction/data ports.
//   MEM_DEPTH words of XLEN bits mapped at BASE_ADDR, with WAIT_STATES
//   stall cycles ahead of every OKAY completion and a two-cycle ERROR
//   response for out-of-range, misaligned or oversize transfers. SEQ beats
//   are decoded exactly like NONSEQ; HBURST/HPROT/HMASTLOCK are ignored.
//
//   Ports:
//     HCLK       in   clock, rising edge
//     HRESET     in   asynchronous active-high reset
//     ahb        slave modport of pu_riscv_ahb3_slave_mem_if
//     dbg_state  out  current responder state
// ---------------------------------------------------------------------------
module pu_riscv_ahb3_slave_mem
  import pu_riscv_ahb3_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter int              PLEN        = 64,
  parameter logic [PLEN-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int              MEM_DEPTH   = 256,
  parameter int              WAIT_STATES = 0
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  pu_riscv_ahb3_slave_mem_if.slave         ahb,
  output ahb3_state_t                      dbg_state
);

  localparam int              NB        = XLEN / 8;
  localparam int              AW        = $clog2(NB);
  localparam int              IW        = $clog2(MEM_DEPTH);
  localparam logic [PLEN-1:0] MEM_BYTES = PLEN'(MEM_DEPTH * NB);
  localparam logic [3:0]      WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // ------------------------------------------------------------------------
  // Address-phase decode
  // ------------------------------------------------------------------------
  logic            accept;
  logic [PLEN-1:0] offset;
  logic            range_err;
  logic            align_err;
  logic            addr_err;
  logic [NB-1:0]   be;
  logic [IW-1:0]   idx;

  assign accept    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign offset    = ahb.HADDR - BASE_ADDR;
  // Below-base addresses wrap to a huge offset, but check explicitly so the
  // decode does not depend on BASE_ADDR/MEM_BYTES arithmetic corner cases.
  assign range_err = (ahb.HADDR < BASE_ADDR) | (offset >= MEM_BYTES);
  assign addr_err  = range_err | align_err;
  assign idx       = offset[AW +: IW];

  pu_riscv_ahb3_be_gen #(
    .XLEN (XLEN)
  ) u_be_gen (
    .hsize   (ahb.HSIZE),
    .addr_lo (ahb.HADDR[AW-1:0]),
    .be      (be),
    .err     (align_err)
  );

  // Where an accepted transfer goes next, and the registered responses that
  // go with that state. Shared by IDLE, DATA and ERR2 (pipelined accept).
  ahb3_state_t start_state;
  logic        start_ready;
  logic        start_resp;

  always_comb begin
    start_state = ST_DATA;
    start_ready = 1'b1;
    start_resp  = HRESP_OKAY;
    if (addr_err) begin
      start_state = ST_ERR1;
      start_ready = 1'b0;
      start_resp  = HRESP_ERROR;
    end else if (WAIT_STATES > 0) begin
      start_state = ST_WAIT;
      start_ready = 1'b0;
    end
  end

  // ------------------------------------------------------------------------
  // Responder FSM with registered HREADYOUT/HRESP
  // ------------------------------------------------------------------------
  ahb3_state_t   state;
  logic [3:0]    wait_cnt;
  logic [IW-1:0] a_idx;
  logic          a_write;
  logic [NB-1:0] a_be;
  logic          rdy_q;
  logic          resp_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      a_idx    <= '0;
      a_write  <= 1'b0;
      a_be     <= '0;
      rdy_q    <= 1'b1;
      resp_q   <= HRESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state  <= ST_DATA;
            rdy_q  <= 1'b1;
            resp_q <= HRESP_OKAY;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state  <= ST_ERR2;
          rdy_q  <= 1'b1;
          resp_q <= HRESP_ERROR;
        end
        default: begin
          // ST_IDLE, ST_DATA, ST_ERR2: bus HREADY is high, so a new address
          // phase may be taken in the same cycle another one completes.
          if (accept) begin
            state    <= start_state;
            rdy_q    <= start_ready;
            resp_q   <= start_resp;
            wait_cnt <= WS_LOAD;
            a_idx    <= idx;
            a_write  <= ahb.HWRITE;
            a_be     <= be;
          end else begin
            state  <= ST_IDLE;
            rdy_q  <= 1'b1;
            resp_q <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Storage. The write commits on the edge that ends the DATA cycle, so a
  // read whose data phase immediately follows already sees the new bytes.
  // An asynchronous reset forces ST_IDLE before the edge, so a transfer
  // caught by reset never writes.
  // ------------------------------------------------------------------------
  logic [XLEN-1:0] mem [MEM_DEPTH];

  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && a_write) begin
      for (int b = 0; b < NB; b++) begin
        if (a_be[b]) mem[a_idx][8*b +: 8] <= ahb.HWDATA[8*b +: 8];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign ahb.HRDATA    = (state == ST_DATA && !a_write) ? mem[a_idx] : '0;
  assign ahb.HREADYOUT = rdy_q;
  assign ahb.HRESP     = resp_q;
  assign dbg_state     = state;

  // Bus fields this memory does not act on, plus offset bits outside the
  // word index.
  logic unused_ok;
  assign unused_ok = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, offset};

endmodule

// File: tb/tb_pu_riscv_ahb3_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_pu_riscv_ahb3_slave_mem
//   Two memories on one bench: dut0 with no wait states and dut3 with three.
//   use_ws picks which one the bench master talks to. A byte-array model
//   holds the expected memory image; the error rule, byte lanes and word
//   read-back are computed from address arithmetic.
// ---------------------------------------------------------------------------
module tb_pu_riscv_ahb3_slave_mem;
  import pu_riscv_ahb3_pkg::*;

  localparam int          XLEN      = 64;
  localparam int          PLEN      = 64;
  localparam int          MEM_DEPTH = 256;
  localparam int          MEM_BYTES = MEM_DEPTH * XLEN / 8;
  localparam logic [63:0] BASE      = 64'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus and DUTs ----------------
  pu_riscv_ahb3_slave_mem_if #(.XLEN(XLEN), .PLEN(PLEN)) bus0 ();
  pu_riscv_ahb3_slave_mem_if #(.XLEN(XLEN), .PLEN(PLEN)) bus3 ();
  ahb3_state_t dbg0, dbg3;

  logic            use_ws;
  logic            hsel, hwrite;
  logic [1:0]      htrans;
  logic [2:0]      hsize;
  logic [PLEN-1:0] haddr;
  logic [XLEN-1:0] hwdata;
  logic            bus_ready, bus_resp;
  logic [XLEN-1:0] bus_rdata;

  assign bus_ready = use_ws ? bus3.HREADYOUT : bus0.HREADYOUT;
  assign bus_resp  = use_ws ? bus3.HRESP     : bus0.HRESP;
  assign bus_rdata = use_ws ? bus3.HRDATA    : bus0.HRDATA;

  assign bus0.HSEL = hsel & ~use_ws;
  assign bus3.HSEL = hsel & use_ws;
  assign bus0.HADDR = haddr;      assign bus3.HADDR = haddr;
  assign bus0.HWDATA = hwdata;    assign bus3.HWDATA = hwdata;
  assign bus0.HWRITE = hwrite;    assign bus3.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;      assign bus3.HSIZE = hsize;
  assign bus0.HBURST = 3'd0;      assign bus3.HBURST = 3'd0;
  assign bus0.HPROT = 4'b0011;    assign bus3.HPROT = 4'b0011;
  assign bus0.HTRANS = htrans;    assign bus3.HTRANS = htrans;
  assign bus0.HMASTLOCK = 1'b0;   assign bus3.HMASTLOCK = 1'b0;
  assign bus0.HREADY = bus_ready; assign bus3.HREADY = bus_ready;

  pu_riscv_ahb3_slave_mem #(
    .XLEN(XLEN), .PLEN(PLEN), .BASE_ADDR(BASE), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(0)
  ) dut0 (.HCLK(clk), .HRESET(rst), .ahb(bus0.slave), .dbg_state(dbg0));

  pu_riscv_ahb3_slave_mem #(
    .XLEN(XLEN), .PLEN(PLEN), .BASE_ADDR(BASE), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(3)
  ) dut3 (.HCLK(clk), .HRESET(rst), .ahb(bus3.slave), .dbg_state(dbg3));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [7:0]      ref_mem [MEM_BYTES];
  logic [XLEN-1:0] exp_q [$];
  logic [XLEN-1:0] last_rd;

  function automatic bit ref_err(input logic [63:0] a, input logic [2:0] s);
    longint unsigned nb;
    nb = 64'd1 << s;
    if (s > 3'd3) return 1'b1;
    if ((a % nb) != 0) return 1'b1;
    if (a < BASE) return 1'b1;
    if ((a - BASE) >= 64'(MEM_BYTES)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    int off;
    logic [63:0] w;
    off = int'(a - BASE) & ~7;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[off + i];
    return w;
  endfunction

  function automatic void ref_write(input logic [63:0] a, input logic [2:0] s, input logic [63:0] d);
    int off;
    off = int'(a - BASE);
    for (int i = 0; i < (1 << s); i++) ref_mem[off + i] = d[8*((off + i) % 8) +: 8];
  endfunction

  // ---------------- transfer queue and driver ----------------
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
  } xfer_t;

  xfer_t xq [$];

  task automatic push(input logic sel, input logic [1:0] tr, input logic w,
                      input logic [2:0] sz, input logic [63:0] a, input logic [63:0] d);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.write = w; x.size = sz; x.addr = a; x.wdata = d;
    xq.push_back(x);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      int kind;
      logic [2:0] sz;
      logic [63:0] off;
      logic [63:0] a;
      logic [1:0] tr;
      logic sel;
      kind = $urandom_range(0, 11);
      sz   = 3'($urandom_range(0, 3));
      off  = 64'($urandom_range(0, 127)) & ~((64'd1 << sz) - 64'd1);
      case (kind)
        8:  if (sz != 3'd0) off = off | 64'd1;
        9:  sz = 3'($urandom_range(4, 7));
        10: off = 64'h800 + 64'($urandom_range(0, 255)) * 8;
        default: ;
      endcase
      a = BASE + off;
      if (kind == 11) a = BASE - 64'($urandom_range(1, 16)) * 8;
      sel = ($urandom_range(0, 7) != 0);
      tr  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      push(sel, tr, 1'($urandom_range(0, 1)), sz, a, {$urandom(), $urandom()});
    end
  endtask

  // Issues the queued transfers back-to-back, one address phase per ready
  // cycle, and checks every data phase at the falling edge.
  task automatic run_xfers();
    xfer_t       cur;
    bit          have_dp = 1'b0;
    bit          dp_err  = 1'b0;
    bit          dp_write = 1'b0;
    logic [63:0] dp_wdata = '0;
    int          waits = 0;
    int          budget = 0;
    int          ws_cur;
    ws_cur = use_ws ? 3 : 0;
    while ((xq.size() > 0 || have_dp) && budget < 4000) begin
      budget++;
      if (xq.size() > 0) begin
        cur = xq[0];
        hsel = cur.sel; htrans = cur.trans; hwrite = cur.write;
        hsize = cur.size; haddr = cur.addr;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE;
      end
      hwdata = (have_dp && dp_write) ? dp_wdata : {$urandom(), $urandom()};
      @(negedge clk);
      if (have_dp) begin
        if (!bus_ready) begin
          waits++;
          check_eq("wait_resp", 64'(bus_resp), 64'(dp_err));
          if (waits > 20) begin
            checks++; failures++;
            $display("FAIL wait_bound got=%0d waits exp<=%0d", waits, ws_cur);
            have_dp = 1'b0;
            void'(exp_q.pop_front());
          end
        end else begin
          check_eq("resp", 64'(bus_resp), 64'(dp_err));
          check_eq("waits", 64'(waits), dp_err ? 64'd1 : 64'(ws_cur));
          check_eq("rdata", bus_rdata, exp_q.pop_front());
          if (!dp_write && !dp_err) last_rd = bus_rdata;
          have_dp = 1'b0;
        end
      end else begin
        check_eq("idle_ready", 64'(bus_ready), 64'd1);
        check_eq("idle_resp", 64'(bus_resp), 64'd0);
        check_eq("idle_rdata", bus_rdata, 64'd0);
      end
      if (bus_ready && xq.size() > 0) begin
        cur = xq.pop_front();
        if (cur.sel && cur.trans[1]) begin
          have_dp  = 1'b1;
          dp_err   = ref_err(cur.addr, cur.size);
          dp_write = cur.write;
          dp_wdata = cur.wdata;
          waits    = 0;
          if (!dp_err && cur.write) ref_write(cur.addr, cur.size, cur.wdata);
          exp_q.push_back((dp_err || cur.write) ? 64'd0 : ref_word(cur.addr));
        end
      end
      @(posedge clk); #1;
    end
    if (xq.size() > 0 || have_dp) begin
      checks++; failures++;
      $display("FAIL run_budget got=%0d pending exp=0", xq.size());
      xq.delete();
      exp_q.delete();
    end
    hsel = 1'b0; htrans = HTRANS_IDLE;
  endtask

  task automatic init_words();
    for (int w = 0; w < 16; w++) push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_B64, BASE + 64'(8 * w), 64'd0);
    run_xfers();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; use_ws = 1'b0;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'd0; haddr = '0; hwdata = '0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready0", 64'(bus0.HREADYOUT), 64'd1);
    check_eq("rst_resp0", 64'(bus0.HRESP), 64'd0);
    check_eq("rst_rdata0", bus0.HRDATA, 64'd0);
    check_eq("rst_state0", 64'(dbg0), 64'(ST_IDLE));
    check_eq("rst_ready3", 64'(bus3.HREADYOUT), 64'd1);
    check_eq("rst_state3", 64'(dbg3), 64'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // ----- zero wait states -----
    init_words();

    // write then read the same word back-to-back
    push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_B64, 64'h8000_0010, 64'h0123_4567_89AB_CDEF);
    push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_B64, 64'h8000_0010, 64'd0);
    run_xfers();
    check_eq("pipe_rd", last_rd, 64'h0123_4567_89AB_CDEF);

    // single byte into lane 3 of a zero word
    push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_B64, 64'h8000_0010, 64'd0);
    push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_B8,  64'h8000_0013, 64'h1111_1111_AA11_1111);
    push(1'b1, HTRANS_SEQ,    1'b0, HSIZE_B64, 64'h8000_0010, 64'd0);
    run_xfers();
    check_eq("byte_wr", last_rd, 64'h0000_0000_AA00_0000);

    // out of range read, misaligned word write, then confirm no write
    push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_B64, 64'h8000_0800, 64'd0);
    push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_B32, 64'h8000_0002, 64'hFFFF_FFFF_FFFF_FFFF);
    push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_B64, 64'h8000_0000, 64'd0);
    run_xfers();
    check_eq("err_nowrite", last_rd, 64'd0);

    // BUSY / IDLE selected, NONSEQ unselected: none may touch memory
    push(1'b1, HTRANS_BUSY,   1'b1, HSIZE_B64, 64'h8000_0018, 64'hDEAD_BEEF_DEAD_BEEF);
    push(1'b1, HTRANS_IDLE,   1'b1, HSIZE_B64, 64'h8000_0018, 64'hDEAD_BEEF_DEAD_BEEF);
    push(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_B64, 64'h8000_0018, 64'hDEAD_BEEF_DEAD_BEEF);
    push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_B64, 64'h8000_0018, 64'd0);
    run_xfers();
    check_eq("idle_nowrite", last_rd, 64'd0);

    push_random(150);
    run_xfers();

    // ----- three wait states -----
    use_ws = 1'b1;
    @(posedge clk); #1;
    init_words();
    push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_B64, 64'h8000_0028, 64'hCAFE_F00D_1234_5678);
    push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_B64, 64'h8000_0028, 64'd0);
    push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_B64, 64'h8000_0800, 64'd0);
    push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_B16, 64'h8000_0021, 64'd0);
    run_xfers();
    check_eq("ws_rd", last_rd, 64'hCAFE_F00D_1234_5678);

    push_random(80);
    run_xfers();

    // reset while a write to word 5 is stalled in its wait states
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_B64;
    haddr = BASE + 64'd40;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    hwdata = 64'h5555_6666_7777_8888;
    check_eq("mid_wr_stall", 64'(bus3.HREADYOUT), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_ready", 64'(bus3.HREADYOUT), 64'd1);
    check_eq("rst_mid_resp", 64'(bus3.HRESP), 64'd0);
    check_eq("rst_mid_rdata", bus3.HRDATA, 64'd0);
    check_eq("rst_mid_state", 64'(dbg3), 64'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_B64, BASE + 64'd40, 64'd0);
    run_xfers();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
